wb_mc_arbiter: RTL and testbench

//  Parametrised N-master -> 1-slave pipelined Wishbone arbiter; successor to the fixed cpu/dma

---
 rtl/wb_mc_arbiter_pkg.sv | 30 +++
 rtl/wb_mc_arbiter_rr_grant.sv | 45 ++++
 rtl/wb_mc_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_wb_mc_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mc_arbiter_pkg.sv
// ------------------------------------------------------------------
// wb_mc_arbiter_pkg : shared types and helpers for the WB arbiter
// Rev 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

package wb_mc_arbiter_pkg;

    localparam int C_MAX_MASTERS = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // An index still needs one bit when there is a single master.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_mc_arbiter_rr_grant.sv
// ------------------------------------------------------------------
// wb_mc_arbiter_rr_grant : combinational round-robin one-hot picker
// Rev 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

module wb_mc_arbiter_rr_grant #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    int w_best;
    int w_best_dist;
    int w_dist;

    // Distance 0 is the master right after the pointer; the pointer itself is last.
    always_comb begin
        w_best      = -1;
        w_best_dist = N;
        w_dist      = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + 2 * N - int'(pointer) - 1) % N;
            if (req[j] && (w_dist < w_best_dist)) begin
                w_best      = j;
                w_best_dist = w_dist;
            end
        end
        grant = '0;
        index = '0;
        for (int j = 0; j < N; j++) begin
            if (j == w_best) begin
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mc_arbiter.sv
// ------------------------------------------------------------------
// wb_mc_arbiter : N-master -> 1-slave pipelined Wishbone arbiter
// Optional ack watchdog enabled by WB_ARB_TIMEOUT_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_mc_arbiter
    import wb_mc_arbiter_pkg::*;
#(
    parameter int MASTER_NUMBER   = 3,
    parameter int ADR_WIDTH       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [MASTER_NUMBER-1:0]                m_cyc,
    input  logic [MASTER_NUMBER-1:0]                m_stb,
    input  logic [MASTER_NUMBER-1:0]                m_we,
    input  logic [MASTER_NUMBER*ADR_WIDTH-1:0]      m_adr,
    input  logic [MASTER_NUMBER*DATA_WIDTH/8-1:0]   m_sel,
    input  logic [MASTER_NUMBER*DATA_WIDTH-1:0]     m_dat_w,
    output logic [DATA_WIDTH-1:0]                   m_dat_r,
    output logic [MASTER_NUMBER-1:0]                m_ack,
    output logic [MASTER_NUMBER-1:0]                m_stall,
    output logic [MASTER_NUMBER-1:0]                m_err,
    output logic                                    s_cyc,
    output logic                                    s_stb,
    output logic                                    s_we,
    output logic [ADR_WIDTH-1:0]                    s_adr,
    output logic [DATA_WIDTH/8-1:0]                 s_sel,
    output logic [DATA_WIDTH-1:0]                   s_dat_w,
    input  logic [DATA_WIDTH-1:0]                   s_dat_r,
    input  logic                                    s_ack,
    input  logic                                    s_stall,
    output logic [MASTER_NUMBER-1:0]                grant
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = idx_width(MASTER_NUMBER);
    localparam int CNT_W     = clog2(MAX_OUTSTANDING) + 1;

    if (MASTER_NUMBER < 1 || MASTER_NUMBER > C_MAX_MASTERS) begin : g_bad_master_number
        $error("wb_mc_arbiter: MASTER_NUMBER out of range");
    end

    arb_state_t                 r_state, w_state_nxt;
    logic [MASTER_NUMBER-1:0]   r_grant, w_grant_nxt, w_pick_grant;
    logic [IDX_W-1:0]           r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_pick_idx;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic                       w_owned, w_full, w_accept, w_retire, w_timeout;
    logic                       w_own_cyc, w_own_stb, w_own_we;
    logic [ADR_WIDTH-1:0]       w_own_adr;
    logic [SEL_WIDTH-1:0]       w_own_sel;
    logic [DATA_WIDTH-1:0]      w_own_dat;

    wb_mc_arbiter_rr_grant #(
        .N     (MASTER_NUMBER),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req     (m_cyc),
        .pointer (r_ptr),
        .grant   (w_pick_grant),
        .index   (w_pick_idx)
    );

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_sel = '0;
        w_own_dat = '0;
        for (int i = 0; i < MASTER_NUMBER; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_cyc = m_cyc[i];
                w_own_stb = m_stb[i];
                w_own_we  = m_we[i];
                w_own_adr = m_adr[i*ADR_WIDTH +: ADR_WIDTH];
                w_own_sel = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
                w_own_dat = m_dat_w[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_owned  = (r_state == ST_OWNED);
    assign w_full   = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign s_cyc    = w_owned & w_own_cyc & ~w_timeout;
    assign s_stb    = s_cyc & w_own_stb & ~w_full;
    assign s_we     = w_owned & w_own_we;
    assign s_adr    = w_owned ? w_own_adr : '0;
    assign s_sel    = w_owned ? w_own_sel : '0;
    assign s_dat_w  = w_owned ? w_own_dat : '0;
    assign w_accept = s_stb & ~s_stall;
    // Acks with nothing outstanding, or after the owner let go, are dropped.
    assign w_retire = w_owned & w_own_cyc & s_ack & (r_cnt != '0);
    assign m_dat_r  = w_retire ? s_dat_r : '0;
    assign grant    = r_grant;

    always_comb begin
        m_stall = '1;
        m_ack   = '0;
        for (int i = 0; i < MASTER_NUMBER; i++) begin
            if (w_owned && (r_owner == IDX_W'(i))) begin
                m_stall[i] = s_stall | w_full;
                m_ack[i]   = w_retire;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|m_cyc) begin
                    w_state_nxt = ST_OWNED;
                    w_grant_nxt = w_pick_grant;
                    w_owner_nxt = w_pick_idx;
                    w_ptr_nxt   = w_pick_idx;
                end
            end
            ST_OWNED: begin
                if (!w_own_cyc || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (w_accept && !w_retire) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (!w_accept && w_retire) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= IDX_W'(MASTER_NUMBER - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] r_wd;
    logic            w_waiting;

    assign w_waiting = w_owned & w_own_cyc & (r_cnt != '0) & ~s_ack;
    assign w_timeout = w_waiting & (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wd <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    always_comb begin
        m_err = '0;
        for (int i = 0; i < MASTER_NUMBER; i++) begin
            if (r_owner == IDX_W'(i)) m_err[i] = w_timeout;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign m_err            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_mc_arbiter.sv
// ------------------------------------------------------------------
// tb_wb_mc_arbiter : directed table-driven bench for wb_mc_arbiter
// Rev 1.0 - initial release
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_mc_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [95:0] m_adr;
    logic [11:0] m_sel;
    logic [95:0] m_dat_w;
    logic [31:0] m_dat_r;
    logic [2:0]  m_ack, m_stall, m_err, grant;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w;
    logic [31:0] s_dat_r;
    logic        s_ack, s_stall;

    int n_checks = 0;
    int n_fail   = 0;

    wb_mc_arbiter #(
        .MASTER_NUMBER   (3),
        .ADR_WIDTH       (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_sel   (m_sel),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_stall (m_stall),
        .m_err   (m_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_sel   (s_sel),
        .s_dat_w (s_dat_w),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .s_stall (s_stall),
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  cyc, stb;
        logic [31:0] adr;
        logic        ack, stall;
        logic [31:0] dat;
        logic [2:0]  e_grant;
        logic        e_scyc, e_sstb;
        logic [31:0] e_sadr;
        logic [2:0]  e_ack, e_stall;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [2:0] cyc, stb, input logic [31:0] adr,
                                input logic ack, stall, input logic [31:0] dat,
                                input logic [2:0] eg, input logic esc, ess, input logic [31:0] esa,
                                input logic [2:0] ea, es, input logic [31:0] ed);
        vec_t v;
        v.name = n; v.cyc = cyc; v.stb = stb; v.adr = adr; v.ack = ack; v.stall = stall; v.dat = dat;
        v.e_grant = eg; v.e_scyc = esc; v.e_sstb = ess; v.e_sadr = esa;
        v.e_ack = ea; v.e_stall = es; v.e_dat = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master i presents address adr | (i << 12), select 1<<i and write data D000_000i.
    task automatic drive(input logic [2:0] cyc, stb, input logic [31:0] adr,
                         input logic ack, stall, input logic [31:0] dat);
        m_cyc = cyc;
        m_stb = stb;
        for (int i = 0; i < 3; i++) m_adr[i*32 +: 32] = adr | (32'(i) << 12);
        s_ack   = ack;
        s_stall = stall;
        s_dat_r = dat;
    endtask

    task automatic check_row(input vec_t v);
        chk({v.name, "_grant"}, 32'(grant), 32'(v.e_grant));
        chk({v.name, "_s_cyc"}, 32'(s_cyc), 32'(v.e_scyc));
        chk({v.name, "_s_stb"}, 32'(s_stb), 32'(v.e_sstb));
        chk({v.name, "_s_adr"}, s_adr, v.e_sadr);
        chk({v.name, "_m_ack"}, 32'(m_ack), 32'(v.e_ack));
        chk({v.name, "_m_stall"}, 32'(m_stall), 32'(v.e_stall));
        chk({v.name, "_m_dat_r"}, m_dat_r, v.e_dat);
        chk({v.name, "_m_err"}, 32'(m_err), 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        m_we    = 3'b101;
        m_sel   = {4'h4, 4'h2, 4'h1};
        m_dat_w = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset state
        @(negedge clk); #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_m_stall", 32'(m_stall), 32'h7);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_s_adr", s_adr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Burst of four reads from m0, then back-pressure and abort corner cases
        vecs.push_back(mk("t1_idle", 3'b001, 3'b000, 32'h100, 0, 0, 0,           3'b000, 0, 0, 32'h0,   3'b000, 3'b111, 0));
        vecs.push_back(mk("t1_s0",   3'b001, 3'b001, 32'h100, 0, 0, 0,           3'b001, 1, 1, 32'h100, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t1_s1",   3'b001, 3'b001, 32'h104, 1, 0, 32'hA000_0000, 3'b001, 1, 1, 32'h104, 3'b001, 3'b110, 32'hA000_0000));
        vecs.push_back(mk("t1_s2",   3'b001, 3'b001, 32'h108, 1, 0, 32'hA000_0001, 3'b001, 1, 1, 32'h108, 3'b001, 3'b110, 32'hA000_0001));
        vecs.push_back(mk("t1_s3",   3'b001, 3'b001, 32'h10C, 1, 0, 32'hA000_0002, 3'b001, 1, 1, 32'h10C, 3'b001, 3'b110, 32'hA000_0002));
        vecs.push_back(mk("t1_ack4", 3'b001, 3'b000, 32'h10C, 1, 0, 32'hA000_0003, 3'b001, 1, 0, 32'h10C, 3'b001, 3'b110, 32'hA000_0003));
        vecs.push_back(mk("t1_spur", 3'b001, 3'b000, 32'h10C, 1, 0, 32'hFFFF_FFFF, 3'b001, 1, 0, 32'h10C, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t3_sst",  3'b001, 3'b001, 32'h200, 0, 1, 0,           3'b001, 1, 1, 32'h200, 3'b000, 3'b111, 0));
        vecs.push_back(mk("t3_a1",   3'b001, 3'b001, 32'h200, 0, 0, 0,           3'b001, 1, 1, 32'h200, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t3_a2",   3'b001, 3'b001, 32'h204, 0, 0, 0,           3'b001, 1, 1, 32'h204, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t3_a3",   3'b001, 3'b001, 32'h208, 0, 0, 0,           3'b001, 1, 1, 32'h208, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t3_a4",   3'b001, 3'b001, 32'h20C, 0, 0, 0,           3'b001, 1, 1, 32'h20C, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t3_full", 3'b001, 3'b001, 32'h210, 0, 0, 0,           3'b001, 1, 0, 32'h210, 3'b000, 3'b111, 0));
        vecs.push_back(mk("t3_ackf", 3'b001, 3'b001, 32'h210, 1, 0, 32'hB000_0000, 3'b001, 1, 0, 32'h210, 3'b001, 3'b111, 32'hB000_0000));
        vecs.push_back(mk("t3_a5",   3'b001, 3'b001, 32'h210, 0, 0, 0,           3'b001, 1, 1, 32'h210, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t4_ack1", 3'b001, 3'b000, 32'h210, 1, 0, 32'hB000_0001, 3'b001, 1, 0, 32'h210, 3'b001, 3'b111, 32'hB000_0001));
        vecs.push_back(mk("t4_ack2", 3'b001, 3'b000, 32'h210, 1, 0, 32'hB000_0002, 3'b001, 1, 0, 32'h210, 3'b001, 3'b110, 32'hB000_0002));
        vecs.push_back(mk("t4_drop", 3'b000, 3'b000, 32'h210, 0, 0, 0,           3'b001, 0, 0, 32'h210, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t4_late", 3'b000, 3'b000, 32'h210, 1, 0, 32'hC000_0000, 3'b000, 0, 0, 32'h0,   3'b000, 3'b111, 0));
        vecs.push_back(mk("t4_req",  3'b001, 3'b000, 32'h300, 0, 0, 0,           3'b000, 0, 0, 32'h0,   3'b000, 3'b111, 0));
        vecs.push_back(mk("t4_cnt0", 3'b001, 3'b000, 32'h300, 1, 0, 32'hC000_0001, 3'b001, 1, 0, 32'h300, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t4_rel",  3'b000, 3'b000, 32'h300, 0, 0, 0,           3'b001, 0, 0, 32'h300, 3'b000, 3'b110, 0));
        vecs.push_back(mk("t4_idle", 3'b000, 3'b000, 32'h300, 0, 0, 0,           3'b000, 0, 0, 32'h0,   3'b000, 3'b111, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].cyc, vecs[k].stb, vecs[k].adr, vecs[k].ack, vecs[k].stall, vecs[k].dat);
            #1;
            check_row(vecs[k]);
        end

        // Simultaneous requests after reset, then hand-over with one idle cycle
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        drive(3'b101, 3'b000, 32'h400, 1'b0, 1'b0, 32'h0);
        #1; chk("t2_req_grant", 32'(grant), 32'd0);
        @(negedge clk); #1;
        chk("t2_m0_grant", 32'(grant), 32'h1);
        chk("t2_m0_s_cyc", 32'(s_cyc), 32'd1);
        chk("t2_m0_s_sel", 32'(s_sel), 32'h1);
        chk("t2_m0_s_we", 32'(s_we), 32'd1);
        chk("t2_m0_s_dat_w", s_dat_w, 32'hD000_0000);
        chk("t2_m0_stall", 32'(m_stall), 32'h6);
        @(negedge clk); drive(3'b100, 3'b000, 32'h400, 1'b0, 1'b0, 32'h0); #1;
        chk("t2_drop_s_cyc", 32'(s_cyc), 32'd0);
        chk("t2_drop_grant", 32'(grant), 32'h1);
        @(negedge clk); #1;
        chk("t2_gap_grant", 32'(grant), 32'd0);
        chk("t2_gap_s_cyc", 32'(s_cyc), 32'd0);
        @(negedge clk); #1;
        chk("t2_m2_grant", 32'(grant), 32'h4);
        chk("t2_m2_s_cyc", 32'(s_cyc), 32'd1);
        chk("t2_m2_s_adr", s_adr, 32'h2400);
        chk("t2_m2_s_sel", 32'(s_sel), 32'h4);
        chk("t2_m2_s_dat_w", s_dat_w, 32'hD000_0002);
        chk("t2_m2_stall", 32'(m_stall), 32'h3);

        // Asynchronous reset in the middle of a burst
        @(negedge clk); drive(3'b000, 3'b000, 32'h500, 1'b0, 1'b0, 32'h0);
        @(negedge clk); drive(3'b001, 3'b001, 32'h500, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("t5_own_s_stb", 32'(s_stb), 32'd1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("t5_rst_s_stb", 32'(s_stb), 32'd0);
        chk("t5_rst_m_stall", 32'(m_stall), 32'h7);
        chk("t5_rst_s_adr", s_adr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(3'b011, 3'b000, 32'h600, 1'b0, 1'b0, 32'h0);
        #1; chk("t5_idle_grant", 32'(grant), 32'd0);
        @(negedge clk); #1;
        chk("t5_ptr_grant", 32'(grant), 32'h1);

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: one accepted strobe never acked, m1 waiting
        @(negedge clk); drive(3'b011, 3'b001, 32'h700, 1'b0, 1'b0, 32'h0); #1;
        chk("t6_accept", 32'(s_stb), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); drive(3'b011, 3'b000, 32'h700, 1'b0, 1'b0, 32'h0); #1;
            if (k < 16) begin
                chk($sformatf("t6_no_err_%0d", k), 32'(m_err), 32'd0);
            end else begin
                chk("t6_err_pulse", 32'(m_err), 32'h1);
                chk("t6_err_s_cyc", 32'(s_cyc), 32'd0);
            end
        end
        @(negedge clk); #1;
        chk("t6_idle_grant", 32'(grant), 32'd0);
        chk("t6_err_cleared", 32'(m_err), 32'd0);
        @(negedge clk); #1;
        chk("t6_next_grant", 32'(grant), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
